multicore_run_ctrl: RTL and testbench

MULTICORE_RUN_CTRL -- requirements
Module: multicore_run_ctrl

---
 rtl/multicore_pkg.sv | 19 +
 rtl/multicore_run_ctrl_if.sv | 24 ++
 rtl/core_status_slot.sv | 35 +++
 rtl/multicore_run_ctrl.sv | 112 +++++++++++
 tb/tb_multicore_run_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/multicore_pkg.sv
// Shared types for the multicore run controller: FSM states and per-core status codes.
package multicore_pkg;

   localparam int unsigned ST_W = 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } run_state_t;

   typedef logic [ST_W-1:0] core_st_t;

   localparam core_st_t ST_OFF   = 2'b00;
   localparam core_st_t ST_RUN   = 2'b01;
   localparam core_st_t ST_DONE  = 2'b10;
   localparam core_st_t ST_ABORT = 2'b11;

endpackage

// File: rtl/multicore_run_ctrl_if.sv
// Run-control bus between the requester/processor array and multicore_run_ctrl.
interface multicore_run_ctrl_if #(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned CNT_W     = 16
);
   logic                   start;
   logic [NUM_CORES-1:0]   core_mask;
   logic [NUM_CORES-1:0]   end_process;
   logic [2*NUM_CORES-1:0] status;
   logic                   busy;
   logic                   done;
   logic                   timed_out;
   logic [CNT_W-1:0]       cycle_count;

   modport master (
      output start, core_mask, end_process,
      input  status, busy, done, timed_out, cycle_count
   );

   modport slave (
      input  start, core_mask, end_process,
      output status, busy, done, timed_out, cycle_count
   );
endinterface

// File: rtl/core_status_slot.sv
// One core's 2-bit run status; reports whether it is finished (or completing this edge).
module core_status_slot
   import multicore_pkg::*;
(
   input  logic     clock,
   input  logic     reset_n,
   input  logic     load,
   input  logic     mask_in,
   input  logic     enabled,
   input  logic     running,
   input  logic     end_process,
   input  logic     abort,
   output core_st_t status,
   output logic     complete_c
);

   logic finish_c;

   assign finish_c   = running && enabled && (status == ST_RUN) && end_process;
   // Non-participating or already-resolved cores never hold a run open.
   assign complete_c = (status != ST_RUN) || finish_c;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         status <= ST_OFF;
      end else if (load) begin
         status <= mask_in ? ST_RUN : ST_OFF;
      end else if (finish_c) begin
         status <= ST_DONE;
      end else if (running && abort && (status == ST_RUN)) begin
         status <= ST_ABORT;
      end
   end

endmodule

// File: rtl/multicore_run_ctrl.sv
// Launches a run on a set of cores, tracks completion and run length.
// Define RUN_CTRL_TIMEOUT_EN to abort runs reaching TIMEOUT_CYCLES; otherwise the counter saturates.
module multicore_run_ctrl
   import multicore_pkg::*;
#(
   parameter int unsigned NUM_CORES      = 4,
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF
) (
   input logic                  clock,
   input logic                  reset_n,
   multicore_run_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (NUM_CORES < 1 || NUM_CORES > 16) begin : g_bad_cores
      $error("NUM_CORES out of range");
   end
   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 32'(CNT_MAX)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range");
   end

   run_state_t             state;
   logic [NUM_CORES-1:0]   run_mask;
   logic [CNT_W-1:0]       cycle_count;
   logic                   busy;
   logic                   done;
   logic                   timed_out;
   logic [2*NUM_CORES-1:0] status;

   logic                   accept_c;
   logic                   running_c;
   logic [CNT_W-1:0]       cnt_inc_c;
   logic [NUM_CORES-1:0]   complete_c;
   logic                   all_done_c;
   logic                   timeout_c;

   assign accept_c   = bus.start && (|bus.core_mask) && (state != S_RUN);
   assign running_c  = (state == S_RUN);
   assign cnt_inc_c  = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + CNT_W'(1);
   assign all_done_c = &complete_c;

`ifdef RUN_CTRL_TIMEOUT_EN
   // Completion on the timeout edge wins over the abort.
   assign timeout_c = running_c && (cnt_inc_c == CNT_W'(TIMEOUT_CYCLES)) && !all_done_c;
`else
   assign timeout_c = 1'b0;
`endif

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
      core_status_slot u_slot (
         .clock       (clock),
         .reset_n     (reset_n),
         .load        (accept_c),
         .mask_in     (bus.core_mask[i]),
         .enabled     (run_mask[i]),
         .running     (running_c),
         .end_process (bus.end_process[i]),
         .abort       (timeout_c),
         .status      (status[2*i +: 2]),
         .complete_c  (complete_c[i])
      );
   end

   // Run FSM with counter and registered flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         run_mask    <= '0;
         cycle_count <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timed_out   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_FIN: begin
               if (accept_c) begin
                  state       <= S_RUN;
                  run_mask    <= bus.core_mask;
                  cycle_count <= '0;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  timed_out   <= 1'b0;
               end
            end
            S_RUN: begin
               cycle_count <= cnt_inc_c;
               if (all_done_c) begin
                  state     <= S_FIN;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  timed_out <= 1'b0;
               end else if (timeout_c) begin
                  state     <= S_FIN;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  timed_out <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.status      = status;
   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.timed_out   = timed_out;
   assign bus.cycle_count = cycle_count;

endmodule

// File: tb/tb_multicore_run_ctrl.sv
// Scoreboard bench for multicore_run_ctrl (4 cores, 5-bit counter, timeout 20).
module tb_multicore_run_ctrl;

   localparam int unsigned NC = 4;
   localparam int unsigned CW = 5;
   localparam int unsigned TO = 20;
`ifdef RUN_CTRL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clock;
   logic reset_n;

   multicore_run_ctrl_if #(.NUM_CORES(NC), .CNT_W(CW)) bus ();

   multicore_run_ctrl #(
      .NUM_CORES      (NC),
      .CNT_W          (CW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks;
   int n_errors;

   logic [15:0] sb_q[$];

   // Reference model state: 0 idle, 1 run, 2 fin.
   int         m_state;
   int         m_cnt;
   bit         m_busy;
   bit         m_done;
   bit         m_to;
   logic [1:0] m_st[NC];

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] dut_out();
      return {bus.status, bus.busy, bus.done, bus.timed_out, bus.cycle_count};
   endfunction

   function automatic logic [15:0] model_pack();
      return {m_st[3], m_st[2], m_st[1], m_st[0], m_busy, m_done, m_to, 5'(m_cnt)};
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_cnt   = 0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_to    = 1'b0;
      for (int i = 0; i < NC; i++) m_st[i] = 2'b00;
   endtask

   task automatic model_step(input logic s, input logic [3:0] m, input logic [3:0] e);
      int nc;
      bit pending;
      if (m_state != 1) begin
         if (s && m != 4'b0000) begin
            for (int i = 0; i < NC; i++) m_st[i] = m[i] ? 2'b01 : 2'b00;
            m_cnt   = 0;
            m_to    = 1'b0;
            m_busy  = 1'b1;
            m_done  = 1'b0;
            m_state = 1;
         end
      end else begin
         nc = (!TO_EN && m_cnt == 31) ? 31 : m_cnt + 1;
         pending = 1'b0;
         for (int i = 0; i < NC; i++) begin
            if (m_st[i] == 2'b01 && e[i]) m_st[i] = 2'b10;
            if (m_st[i] == 2'b01) pending = 1'b1;
         end
         m_cnt = nc;
         if (!pending) begin
            m_state = 2; m_busy = 1'b0; m_done = 1'b1; m_to = 1'b0;
         end else if (TO_EN && nc == int'(TO)) begin
            m_state = 2; m_busy = 1'b0; m_done = 1'b1; m_to = 1'b1;
            for (int i = 0; i < NC; i++) if (m_st[i] == 2'b01) m_st[i] = 2'b11;
         end
      end
   endtask

   // One clock: drive at negedge, predict, then compare just after the rising edge.
   task automatic step(input logic s, input logic [3:0] m, input logic [3:0] e, input string tag);
      logic [15:0] exp;
      @(negedge clock);
      bus.start       = s;
      bus.core_mask   = m;
      bus.end_process = e;
      model_step(s, m, e);
      sb_q.push_back(model_pack());
      @(posedge clock);
      #1;
      exp = sb_q.pop_front();
      check_eq(tag, dut_out(), exp);
   endtask

   // Launch a run, pulse end_process[i] at run cycle ti, optionally poke start during the run.
   task automatic run(input logic [3:0] mask, input int t0, input int t1, input int t2,
                      input int t3, input logic [3:0] bg, input int n, input bit poke,
                      input string tag);
      logic [3:0] e;
      step(1'b1, mask, bg, tag);
      for (int c = 1; c <= n; c++) begin
         e = bg;
         if (c == t0) e[0] = 1'b1;
         if (c == t1) e[1] = 1'b1;
         if (c == t2) e[2] = 1'b1;
         if (c == t3) e[3] = 1'b1;
         step(poke && c == 2, 4'b1111, e, tag);
      end
   endtask

   initial begin
      n_checks        = 0;
      n_errors        = 0;
      reset_n         = 1'b0;
      bus.start       = 1'b0;
      bus.core_mask   = '0;
      bus.end_process = '0;
      model_reset();

      repeat (2) @(posedge clock);
      #1;
      check_eq("reset", dut_out(), 16'h0000);
      @(negedge clock);
      reset_n = 1'b1;

      step(1'b0, 4'b0000, 4'b1111, "idle_end");

      run(4'b0011, 5, 9, 0, 0, 4'b0000, 9, 1'b1, "r030");
      check_eq("r030_final", dut_out(), {8'h0A, 3'b010, 5'd9});
      repeat (2) step(1'b1, 4'b0000, 4'b1111, "fin_mask0");
      check_eq("fin_hold", dut_out(), {8'h0A, 3'b010, 5'd9});

      run(4'b0001, 7, 0, 0, 0, 4'b1110, 7, 1'b0, "r031");
      check_eq("r031_final", dut_out(), {8'h02, 3'b010, 5'd7});

      run(4'b0100, 0, 0, 3, 0, 4'b0000, 3, 1'b1, "r035");
      check_eq("r035_final", dut_out(), {8'h20, 3'b010, 5'd3});

      run(4'b1111, 0, 0, 4, 0, 4'b0000, 20, 1'b0, "r032");
`ifdef RUN_CTRL_TIMEOUT_EN
      check_eq("r032_c20", dut_out(), {8'hEF, 3'b011, 5'd20});
`else
      check_eq("r032_c20", dut_out(), {8'h65, 3'b100, 5'd20});
`endif
      repeat (15) step(1'b0, 4'b0000, 4'b0000, "r032_sat");
`ifdef RUN_CTRL_TIMEOUT_EN
      check_eq("r032_sat_end", dut_out(), {8'hEF, 3'b011, 5'd20});
`else
      check_eq("r032_sat_end", dut_out(), {8'h65, 3'b100, 5'd31});
`endif
      step(1'b0, 4'b0000, 4'b1011, "r032_end");
`ifdef RUN_CTRL_TIMEOUT_EN
      check_eq("r032_late", dut_out(), {8'hEF, 3'b011, 5'd20});
`else
      check_eq("r032_late", dut_out(), {8'hAA, 3'b010, 5'd31});
`endif

      run(4'b0011, 3, 20, 0, 0, 4'b0000, 20, 1'b0, "r033");
      check_eq("r033_final", dut_out(), {8'h0A, 3'b010, 5'd20});

      step(1'b1, 4'b1001, 4'b0000, "r034_go");
      repeat (3) step(1'b0, 4'b0000, 4'b0000, "r034_run");
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("r034_async", dut_out(), 16'h0000);
      model_reset();
      @(posedge clock);
      #1;
      check_eq("r034_hold", dut_out(), 16'h0000);
      #2;
      reset_n = 1'b1;
      step(1'b1, 4'b0110, 4'b0000, "r034_first");
      check_eq("r034_launch", dut_out(), {8'h14, 3'b100, 5'd0});
      step(1'b0, 4'b0000, 4'b0110, "r034_done");
      check_eq("r034_final", dut_out(), {8'h28, 3'b010, 5'd1});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
